// File: rtl/sensor_uart_framer_if.sv
// Sample-in / serial-out bundle of the sensor UART framer.
// The master drives samples and watches the link status; the framer is the slave.
interface sensor_uart_framer_if;
    logic [35:0] temp_data;
    logic        temp_data_de;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overflow_cnt;

    modport master (
        output temp_data, temp_data_de,
        input  uart_tx, busy, frame_done, overflow_cnt
    );

    modport slave (
        input  temp_data, temp_data_de,
        output uart_tx, busy, frame_done, overflow_cnt
    );
endinterface

// File: rtl/sensor_uart_framer.sv
// Buffers 36-bit sensor samples in a small FIFO and sends each one as a
// 7-byte 8N1 UART frame: header, five payload bytes, additive checksum.
module sensor_uart_framer #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sensor_uart_framer_if.slave  bus
);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [AW:0]      FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      FIFO_EMPTY = {(AW+1){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Checksum covers the five payload bytes only; the header is excluded.
    function automatic logic [7:0] frame_checksum(input logic [35:0] d);
        logic [7:0] sum;
        sum = {4'h0, d[35:32]} + d[31:24] + d[23:16] + d[15:8] + d[7:0];
        return sum;
    endfunction

    state_e          state_q, state_d;
    logic [35:0]     fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [35:0]     head_q, head_d;
    logic [7:0]      frame_q [7];
    logic [7:0]      frame_d [7];
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      ovf_q, ovf_d;
    logic            pop_s, push_s, drop_s, bit_end_s;

    // FIFO bookkeeping and overflow counting.
    always_comb begin
        pop_s  = (state_q == ST_IDLE) && (count_q != FIFO_EMPTY);
        push_s = bus.temp_data_de && ((count_q != FIFO_FULL) || pop_s);
        drop_s = bus.temp_data_de && !push_s;

        wr_ptr_d = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        head_d   = pop_s  ? fifo_mem_q[rd_ptr_q] : head_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop_s && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Frame FSM; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = tx_q;
        bit_end_s  = (baud_cnt_q == BIT_LAST);

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                frame_d[0] = HEADER;
                frame_d[1] = {4'h0, head_q[35:32]};
                frame_d[2] = head_q[31:24];
                frame_d[3] = head_q[23:16];
                frame_d[4] = head_q[15:8];
                frame_d[5] = head_q[7:0];
                frame_d[6] = frame_checksum(head_q);
                byte_idx_d = 3'd0;
                bit_idx_d  = 3'd0;
                baud_cnt_d = CNT_ZERO;
                tx_d       = 1'b0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_cnt_d = CNT_ZERO;
                    bit_idx_d  = 3'd0;
                    tx_d       = frame_q[byte_idx_q][0];
                    shift_d    = {1'b0, frame_q[byte_idx_q][7:1]};
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = CNT_ZERO;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = CNT_ZERO;
                    if (byte_idx_q != 3'd6) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Sample storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= bus.temp_data;
        end
    end

    // State registers; the line goes high at once on reset, abandoning any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= FIFO_EMPTY;
            head_q     <= 36'h0;
            for (int i = 0; i < 7; i++) begin
                frame_q[i] <= 8'h00;
            end
            shift_q    <= 8'h00;
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= CNT_ZERO;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            frame_q    <= frame_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.uart_tx      = tx_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;
    assign bus.overflow_cnt = ovf_q;
endmodule

// File: tb/tb_sensor_uart_framer.sv
// Bench for sensor_uart_framer: a default-rate instance for exact bit timing and a
// fast-rate instance (10 clocks per bit) for the functional scenarios.
module tb_sensor_uart_framer;
    localparam int DIV_D = 434;
    localparam int DIV_F = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sensor_uart_framer_if bus_d ();
    sensor_uart_framer_if bus_f ();

    sensor_uart_framer #(.CLK_FREQ(50000000), .BAUD(115200), .FIFO_DEPTH(4), .HEADER(8'hA5))
        dut_def (.clk(clk), .rst_n(rst_n), .bus(bus_d));
    sensor_uart_framer #(.CLK_FREQ(50000000), .BAUD(5000000), .FIFO_DEPTH(4), .HEADER(8'hA5))
        dut_fast (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    typedef struct {
        logic [35:0] data;
        logic [55:0] frame;
    } vec_t;

    vec_t        vecs [5];
    logic [55:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;

    bit          mon_sel = 1'b0;
    bit          rx_enable = 1'b1;
    bit          rx_active = 1'b0;
    longint      rx_start = 0;
    longint      first_low_cyc = 0;
    logic [55:0] rx_frame = '0;
    logic [55:0] last_frame = '0;
    int          fd_cnt = 0;
    int          busy_bad = 0;
    int          timing_bad = 0;
    int          fmt_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] model_frame(input logic [35:0] d);
        logic [7:0]  b [7];
        logic [55:0] f;
        int          sum;
        b[0] = 8'hA5;
        b[1] = {4'h0, d[35:32]};
        b[2] = d[31:24];
        b[3] = d[23:16];
        b[4] = d[15:8];
        b[5] = d[7:0];
        sum = 0;
        for (int k = 1; k < 6; k++) sum += int'(b[k]);
        b[6] = sum[7:0];
        for (int k = 0; k < 7; k++) f[8*k +: 8] = b[k];
        return f;
    endfunction

    // UART receiver on the selected instance: samples mid-bit and checks edges land on bit boundaries.
    initial begin : monitor
        logic   line, fd, bsy, prev_line;
        logic [55:0] exp_f;
        int     div, bp, pos, byte_i;
        longint rel;
        prev_line = 1'b1;
        forever begin
            @(negedge clk);
            line = mon_sel ? bus_f.uart_tx : bus_d.uart_tx;
            fd   = mon_sel ? bus_f.frame_done : bus_d.frame_done;
            bsy  = mon_sel ? bus_f.busy : bus_d.busy;
            div  = mon_sel ? DIV_F : DIV_D;
            if (bus_d.frame_done || bus_f.frame_done) fd_cnt++;
            if (!rx_enable) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (!line) begin
                    rx_active = 1'b1;
                    rx_start = cyc;
                    first_low_cyc = cyc;
                    busy_bad = 0;
                    timing_bad = 0;
                    fmt_bad = 0;
                    rx_frame = '0;
                end
            end else begin
                rel = cyc - rx_start;
                if (!bsy) busy_bad++;
                if ((line != prev_line) && ((rel % div) != 0)) timing_bad++;
                if (rel == 70 * div) begin
                    check("line_high_after_frame", 64'(line), 64'd1);
                    check("frame_done_after_last_stop", 64'(fd), 64'd1);
                    check("busy_through_frame", 64'(busy_bad), 64'd0);
                    check("bit_edges_on_grid", 64'(timing_bad), 64'd0);
                    check("start_stop_levels", 64'(fmt_bad), 64'd0);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx_frame);
                    end else begin
                        exp_f = sb_q.pop_front();
                        check("frame_bytes", 64'(rx_frame), 64'(exp_f));
                    end
                    last_frame = rx_frame;
                    rx_active = 1'b0;
                end else if ((rel % div) == (div / 2)) begin
                    bp = int'(rel / div);
                    pos = bp % 10;
                    byte_i = bp / 10;
                    if (pos == 0) begin
                        if (line != 1'b0) fmt_bad++;
                    end else if (pos == 9) begin
                        if (line != 1'b1) fmt_bad++;
                    end else begin
                        rx_frame[byte_i*8 + pos - 1] = line;
                    end
                end
            end
            prev_line = line;
        end
    end

    // Consecutive strobes on the fast instance; the first n_acc are expected on the line.
    task automatic burst_f(input logic [35:0] base, input int n, input int n_acc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_f.temp_data = base + 36'(i);
            bus_f.temp_data_de = 1'b1;
            if (i < n_acc) sb_q.push_back(model_frame(base + 36'(i)));
        end
        @(negedge clk);
        bus_f.temp_data_de = 1'b0;
        bus_f.temp_data = 36'h0;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rx_active) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d frames outstanding", name, sb_q.size());
            sb_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        longint strobe_cyc;
        int     fd0, lows, busys, n;

        vecs[0] = '{36'h1_2345_6789, 56'h59_89_67_45_23_01_A5};
        vecs[1] = '{36'hF_FFFF_FFFF, 56'h0B_FF_FF_FF_FF_0F_A5};
        vecs[2] = '{36'h0_0000_0000, 56'h00_00_00_00_00_00_A5};
        vecs[3] = '{36'h3_0000_0001, 56'h04_01_00_00_00_03_A5};
        vecs[4] = '{36'hA_8080_8080, 56'h0A_80_80_80_80_0A_A5};

        rst_n = 1'b0;
        bus_d.temp_data = 36'h0;
        bus_d.temp_data_de = 1'b0;
        bus_f.temp_data = 36'h0;
        bus_f.temp_data_de = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 64'(bus_f.uart_tx), 64'd1);
        check("reset_busy", 64'(bus_f.busy), 64'd0);
        check("reset_frame_done", 64'(bus_f.frame_done), 64'd0);
        check("reset_overflow", 64'(bus_f.overflow_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Default baud: decode, latency and exact 434-cycle bit grid.
        mon_sel = 1'b0;
        fd0 = fd_cnt;
        sb_q.push_back(56'h59_89_67_45_23_01_A5);
        @(negedge clk);
        bus_d.temp_data = 36'h1_2345_6789;
        bus_d.temp_data_de = 1'b1;
        strobe_cyc = cyc;
        @(negedge clk);
        bus_d.temp_data_de = 1'b0;
        bus_d.temp_data = 36'h0;
        wait_drain(40000, "default_frame");
        check("start_latency", 64'(first_low_cyc - strobe_cyc), 64'd3);
        check("default_frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        check("default_overflow", 64'(bus_d.overflow_cnt), 64'd0);

        // Fast baud: table of samples, one frame each.
        mon_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fd0 = fd_cnt;
            sb_q.push_back(vecs[i].frame);
            @(negedge clk);
            bus_f.temp_data = vecs[i].data;
            bus_f.temp_data_de = 1'b1;
            @(negedge clk);
            bus_f.temp_data_de = 1'b0;
            bus_f.temp_data = 36'h0;
            wait_drain(2000, "table_frame");
            check("table_checksum", 64'(last_frame[55:48]), 64'(vecs[i].frame[55:48]));
            check("table_frame_done_count", 64'(fd_cnt - fd0), 64'd1);
        end

        // Burst of 6 into a 4-deep FIFO: sample 6 is dropped.
        fd0 = fd_cnt;
        burst_f(36'd1, 6, 5);
        check("burst_overflow", 64'(bus_f.overflow_cnt), 64'd1);
        wait_drain(6000, "burst_frames");
        check("burst_frame_done_count", 64'(fd_cnt - fd0), 64'd5);

        // Fill the FIFO, then 301 drops during one frame: counter saturates and holds.
        burst_f(36'h0_1234_0100, 306, 5);
        check("overflow_saturated", 64'(bus_f.overflow_cnt), 64'd255);
        burst_f(36'h0_0000_0000, 1, 0);
        check("overflow_holds", 64'(bus_f.overflow_cnt), 64'd255);
        wait_drain(6000, "saturation_frames");

        // Reset during DATA of byte 3 with two samples still queued.
        burst_f(36'h5_0A0B_0C0D, 3, 3);
        n = 0;
        while (!(rx_active && (cyc - rx_start) >= 34 * DIV_F) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte3_data", 64'(n < 2000), 64'd1);
        rx_enable = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_uart_tx", 64'(bus_f.uart_tx), 64'd1);
        check("midreset_busy", 64'(bus_f.busy), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fd0 = fd_cnt;
        lows = 0;
        busys = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!bus_f.uart_tx) lows++;
            if (bus_f.busy) busys++;
        end
        check("postreset_line_quiet", 64'(lows), 64'd0);
        check("postreset_not_busy", 64'(busys), 64'd0);
        check("postreset_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
        check("postreset_overflow", 64'(bus_f.overflow_cnt), 64'd0);
        rx_enable = 1'b1;
        burst_f(36'h7_7654_3210, 1, 1);
        wait_drain(2000, "postreset_frame");
        check("postreset_frame_done_count", 64'(fd_cnt - fd0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
